// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, control field
// values, and the control bundle that travels from ID to EX/MEM/WB.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Write-back kind: LW doubles as "full-word register write" for ALU results
  typedef enum logic [2:0] {NOREGWRITE = 3'd0, LW, LH, LB, LHU, LBU} regwrite_e;
  typedef enum logic [2:0] {NOBRANCH = 3'd0, BEQ, BNE, BLT, BGE, BLTU, BGEU} branch_e;
  typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_e;
  typedef enum logic [2:0] {RTYPE = 3'd0, ITYPE, STYPE, BTYPE, UTYPE, JTYPE} imm_e;

  // Second ALU operand select; first operand is rs1 (0) or PC (1)
  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_FOUR = 2'b01;
  localparam logic [1:0] SRC2_IMM  = 2'b10;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] imm_type;
    logic       jal;
    logic       jalr;
    logic       mem_to_reg;
    logic       load_npc;
    logic       alu_src1;
    logic [2:0] reg_write;
    logic [3:0] mem_write;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src2;
    logic       muldiv;
    logic [2:0] muldiv_op;
    logic       illegal;
  } ctrl_t;

  // ALU op from funct3; alt selects SUB/SRA and is ignored for other funct3
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I instruction decoder: instruction word -> control
// bundle plus illegal flag. RV32M_EN adds MUL..REMU decode on the OP opcode.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  ctrl_t      dec;
  logic       bad;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  // Field decode for legal encodings; bad flags anything outside the ISA
  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.rs1 = instr_i[19:15];
    dec.rs2 = instr_i[24:20];
    dec.rd  = instr_i[11:7];
    case (opc)
      OPC_LUI: begin
        dec.imm_type  = UTYPE;
        dec.reg_write = LW;
        dec.alu_src2  = SRC2_IMM;
      end
      OPC_AUIPC: begin
        dec.imm_type  = UTYPE;
        dec.reg_write = LW;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = SRC2_IMM;
      end
      OPC_JAL: begin
        dec.imm_type  = JTYPE;
        dec.jal       = 1'b1;
        dec.load_npc  = 1'b1;
        dec.reg_write = LW;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = SRC2_IMM;
      end
      OPC_JALR: begin
        dec.imm_type  = ITYPE;
        dec.jalr      = 1'b1;
        dec.load_npc  = 1'b1;
        dec.reg_write = LW;
        dec.reg_read  = 2'b10;
        dec.alu_src2  = SRC2_IMM;
      end
      OPC_BRANCH: begin
        // ALU forms the target (PC + imm); comparison is carried by branch_type
        dec.imm_type = BTYPE;
        dec.reg_read = 2'b11;
        dec.alu_src1 = 1'b1;
        dec.alu_src2 = SRC2_IMM;
        case (f3)
          3'b000:  dec.branch_type = BEQ;
          3'b001:  dec.branch_type = BNE;
          3'b100:  dec.branch_type = BLT;
          3'b101:  dec.branch_type = BGE;
          3'b110:  dec.branch_type = BLTU;
          3'b111:  dec.branch_type = BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm_type   = ITYPE;
        dec.reg_read   = 2'b10;
        dec.mem_to_reg = 1'b1;
        dec.alu_src2   = SRC2_IMM;
        case (f3)
          3'b000:  dec.reg_write = LB;
          3'b001:  dec.reg_write = LH;
          3'b010:  dec.reg_write = LW;
          3'b100:  dec.reg_write = LBU;
          3'b101:  dec.reg_write = LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm_type = STYPE;
        dec.reg_read = 2'b11;
        dec.alu_src2 = SRC2_IMM;
        case (f3)
          3'b000:  dec.mem_write = 4'b0001;
          3'b001:  dec.mem_write = 4'b0011;
          3'b010:  dec.mem_write = 4'b1111;
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.imm_type  = ITYPE;
        dec.reg_read  = 2'b10;
        dec.reg_write = LW;
        dec.alu_src2  = SRC2_IMM;
        // funct7 is immediate data except for the shift-by-shamt forms
        dec.alu_ctrl  = alu_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        if ((f3 == 3'b001) && (f7 != F7_BASE)) bad = 1'b1;
        if ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT)) bad = 1'b1;
      end
      OPC_OP: begin
        dec.imm_type  = RTYPE;
        dec.reg_read  = 2'b11;
        dec.reg_write = LW;
        dec.alu_src2  = SRC2_REG;
        if (f7 == F7_BASE) begin
          dec.alu_ctrl = alu_op(f3, 1'b0);
        end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          dec.alu_ctrl = alu_op(f3, 1'b1);
        end else if (f7 == F7_MULDIV) begin
`ifdef RV32M_EN
          dec.muldiv    = 1'b1;
          dec.muldiv_op = f3;
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  // Illegal words carry only their raw register indices plus the flag
  always_comb begin
    ctrl_o = dec;
    if (bad) begin
      ctrl_o         = '0;
      ctrl_o.rs1     = dec.rs1;
      ctrl_o.rs2     = dec.rs2;
      ctrl_o.rd      = dec.rd;
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Registered, flow-controlled ID stage. Decodes at the input, holds an
// output entry plus one skid entry so in_ready is a pure register, and
// counts accepted illegal instructions (saturating, survives flush).
// Optional macro RV32M_EN enables MUL..REMU decode inside decode_comb.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_imm_type,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_mem_to_reg,
  output logic             out_load_npc,
  output logic             out_alu_src1,
  output logic [2:0]       out_reg_write,
  output logic [3:0]       out_mem_write,
  output logic [1:0]       out_reg_read,
  output logic [2:0]       out_branch_type,
  output logic [3:0]       out_alu_ctrl,
  output logic [1:0]       out_alu_src2,
  output logic             out_muldiv,
  output logic [2:0]       out_muldiv_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t             dec;
  ctrl_t             o_q, o_d, s_q, s_d;
  logic [PC_W-1:0]   o_pc_q, o_pc_d, s_pc_q, s_pc_d;
  logic              o_vld_q, o_vld_d, s_vld_q, s_vld_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, o_free;

  decode_comb u_dec (
    .instr_i (in_instr),
    .ctrl_o  (dec)
  );

  // A flushed cycle drops the offered instruction entirely
  assign accept = in_valid && rdy_q && !flush;
  assign o_free = !o_vld_q || out_ready;

  // O/S steering: skid drains into O first; in_ready is low whenever S holds
  // data, so an accept never coincides with a pending skid entry
  always_comb begin
    o_d     = o_q;
    o_pc_d  = o_pc_q;
    o_vld_d = o_vld_q;
    s_d     = s_q;
    s_pc_d  = s_pc_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      o_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (o_free) begin
      if (s_vld_q) begin
        o_d     = s_q;
        o_pc_d  = s_pc_q;
        o_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (accept) begin
        o_d     = dec;
        o_pc_d  = in_pc;
        o_vld_d = 1'b1;
      end else begin
        o_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_d     = dec;
      s_pc_d  = in_pc;
      s_vld_d = 1'b1;
    end
    rdy_d = !s_vld_d;
  end

  // Saturating illegal-instruction count over accepted words
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset empties both entries and zeroes all fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      o_pc_q  <= '0;
      o_vld_q <= 1'b0;
      s_q     <= '0;
      s_pc_q  <= '0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      o_q     <= o_d;
      o_pc_q  <= o_pc_d;
      o_vld_q <= o_vld_d;
      s_q     <= s_d;
      s_pc_q  <= s_pc_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready        = rdy_q;
  assign out_valid       = o_vld_q;
  assign out_pc          = o_pc_q;
  assign out_rs1         = o_q.rs1;
  assign out_rs2         = o_q.rs2;
  assign out_rd          = o_q.rd;
  assign out_imm_type    = o_q.imm_type;
  assign out_jal         = o_q.jal;
  assign out_jalr        = o_q.jalr;
  assign out_mem_to_reg  = o_q.mem_to_reg;
  assign out_load_npc    = o_q.load_npc;
  assign out_alu_src1    = o_q.alu_src1;
  assign out_reg_write   = o_q.reg_write;
  assign out_mem_write   = o_q.mem_write;
  assign out_reg_read    = o_q.reg_read;
  assign out_branch_type = o_q.branch_type;
  assign out_alu_ctrl    = o_q.alu_ctrl;
  assign out_alu_src2    = o_q.alu_src2;
  // Without RV32M_EN the decoder never sets these, so they stay 0
  assign out_muldiv      = o_q.muldiv;
  assign out_muldiv_op   = o_q.muldiv_op;
  assign out_illegal     = o_q.illegal;
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed steps then random traffic, checked against
// a queue-based occupancy model and a mnemonic-level decode model.
module tb_decode_pipe;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_imm_type, out_reg_write, out_branch_type, out_muldiv_op;
  logic        out_jal, out_jalr, out_mem_to_reg, out_load_npc, out_alu_src1, out_muldiv, out_illegal;
  logic [3:0]  out_mem_write, out_alu_ctrl;
  logic [1:0]  out_reg_read, out_alu_src2;
  logic [15:0] illegal_cnt;
  // second instance with a 2-bit counter to reach saturation quickly
  logic        rdy2, vld2, jal2, jalr2, m2r2, lnpc2, src1_2, md2, ill2;
  logic [31:0] pc2;
  logic [4:0]  rs1_2, rs2_2, rd2;
  logic [2:0]  it2, rw2, bt2, mdop2;
  logic [3:0]  mw2, alu2;
  logic [1:0]  rr2, src2_2, cnt2;

  always #5 clk = ~clk;

  decode_pipe #(.PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm_type(out_imm_type),
    .out_jal(out_jal), .out_jalr(out_jalr), .out_mem_to_reg(out_mem_to_reg),
    .out_load_npc(out_load_npc), .out_alu_src1(out_alu_src1), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_reg_read(out_reg_read), .out_branch_type(out_branch_type),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src2(out_alu_src2), .out_muldiv(out_muldiv),
    .out_muldiv_op(out_muldiv_op), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt));

  decode_pipe #(.PC_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(vld2), .out_ready(out_ready), .out_pc(pc2),
    .out_rs1(rs1_2), .out_rs2(rs2_2), .out_rd(rd2), .out_imm_type(it2),
    .out_jal(jal2), .out_jalr(jalr2), .out_mem_to_reg(m2r2),
    .out_load_npc(lnpc2), .out_alu_src1(src1_2), .out_reg_write(rw2),
    .out_mem_write(mw2), .out_reg_read(rr2), .out_branch_type(bt2),
    .out_alu_ctrl(alu2), .out_alu_src2(src2_2), .out_muldiv(md2),
    .out_muldiv_op(mdop2), .out_illegal(ill2), .illegal_cnt(cnt2));

  typedef struct packed { logic [31:0] pc; ctrl_t c; } ent_t;

  ctrl_t obs_c;
  ent_t  obs_e;
  assign obs_c = {out_rs1, out_rs2, out_rd, out_imm_type, out_jal, out_jalr, out_mem_to_reg,
                  out_load_npc, out_alu_src1, out_reg_write, out_mem_write, out_reg_read,
                  out_branch_type, out_alu_ctrl, out_alu_src2, out_muldiv, out_muldiv_op, out_illegal};
  assign obs_e = {out_pc, obs_c};

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  int   cnt_exp = 0;
  int   cnt2_exp = 0;
  logic acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA tables, mnemonic by mnemonic
  function automatic ctrl_t ref_dec(input logic [31:0] i);
    ctrl_t      e;
    logic       ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [2:0] bt_tbl [8];
    logic [2:0] ld_tbl [8];
    logic [3:0] alu_tbl [8];
    int         bytes;
    bt_tbl  = '{BEQ, BNE, NOBRANCH, NOBRANCH, BLT, BGE, BLTU, BGEU};
    ld_tbl  = '{LB, LH, LW, NOREGWRITE, LBU, LHU, NOREGWRITE, NOREGWRITE};
    alu_tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '0; ok = 1'b1;
    if (op == OPC_LUI || op == OPC_AUIPC) begin
      e.imm_type = UTYPE; e.reg_write = LW; e.alu_src2 = 2'b10; e.alu_src1 = (op == OPC_AUIPC);
    end else if (op == OPC_JAL || op == OPC_JALR) begin
      e.jal = (op == OPC_JAL); e.jalr = (op == OPC_JALR); e.load_npc = 1'b1;
      e.reg_write = LW; e.alu_src2 = 2'b10;
      e.alu_src1 = e.jal; e.imm_type = e.jal ? JTYPE : ITYPE; e.reg_read = e.jal ? 2'b00 : 2'b10;
    end else if (op == OPC_BRANCH) begin
      ok = (bt_tbl[f3] != NOBRANCH);
      e.branch_type = bt_tbl[f3]; e.imm_type = BTYPE; e.reg_read = 2'b11;
      e.alu_src1 = 1'b1; e.alu_src2 = 2'b10;
    end else if (op == OPC_LOAD) begin
      ok = (ld_tbl[f3] != NOREGWRITE);
      e.reg_write = ld_tbl[f3]; e.imm_type = ITYPE; e.reg_read = 2'b10;
      e.mem_to_reg = 1'b1; e.alu_src2 = 2'b10;
    end else if (op == OPC_STORE) begin
      ok = (f3 < 3);
      bytes = 1 << f3;
      e.mem_write = 4'((1 << bytes) - 1); e.imm_type = STYPE; e.reg_read = 2'b11; e.alu_src2 = 2'b10;
    end else if (op == OPC_OPIMM) begin
      e.imm_type = ITYPE; e.reg_read = 2'b10; e.reg_write = LW; e.alu_src2 = 2'b10;
      e.alu_ctrl = alu_tbl[f3];
      if (f3 == 1) ok = (f7 == 0);
      if (f3 == 5) begin
        ok = (f7 == 0) || (f7 == 7'h20);
        if (f7 == 7'h20) e.alu_ctrl = ALU_SRA;
      end
    end else if (op == OPC_OP) begin
      e.imm_type = RTYPE; e.reg_read = 2'b11; e.reg_write = LW; e.alu_src2 = 2'b00;
      if (f7 == 0) e.alu_ctrl = alu_tbl[f3];
      else if (f7 == 7'h20 && f3 == 0) e.alu_ctrl = ALU_SUB;
      else if (f7 == 7'h20 && f3 == 5) e.alu_ctrl = ALU_SRA;
`ifdef RV32M_EN
      else if (f7 == 1) begin e.muldiv = 1'b1; e.muldiv_op = f3; end
`endif
      else ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin e = '0; e.illegal = 1'b1; end
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 9))
      1: return {r[31:7], OPC_LUI};
      2: return {r[31:7], OPC_AUIPC};
      3: return {r[31:7], OPC_JAL};
      4: return {r[31:15], 3'b000, r[11:7], OPC_JALR};
      5: return {r[31:7], OPC_BRANCH};
      6: return {r[31:7], OPC_LOAD};
      7: return {r[31:7], OPC_STORE};
      8: return {f7, r[24:7], OPC_OPIMM};
      9: return {f7, r[24:7], OPC_OP};
      default: return r;
    endcase
  endfunction

  // Compare visible state with the model, then drive one cycle and advance it
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, output logic a);
    ctrl_t e;
    logic  drn;
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("illegal_cnt", 128'(illegal_cnt), 128'(cnt_exp));
    chk("illegal_cnt_w2", 128'(cnt2), 128'(cnt2_exp));
    if (q.size() > 0) chk("bundle", 128'(obs_e), 128'(q[0]));
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    e   = ref_dec(ins);
    a   = v && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (a) q.push_back({pc, e});
    end
    if (a && e.illegal) begin
      if (cnt_exp < 65535) cnt_exp++;
      if (cnt2_exp < 3) cnt2_exp++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] strm [4];
  logic [31:0] ins_r, pc_r;
  int          k, cnt_before;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("reset_fields", 128'(obs_e), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_cnt", 128'(illegal_cnt), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, acc);
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_alu", 128'(out_alu_ctrl), 128'(ALU_ADD));
    chk("addi_src2", 128'(out_alu_src2), 128'(2'b10));
    chk("addi_rr", 128'(out_reg_read), 128'(2'b10));
    chk("addi_rw", 128'(out_reg_write), 128'(LW));
    chk("addi_imm", 128'(out_imm_type), 128'(ITYPE));
    chk("addi_rd", 128'(out_rd), 128'(1));
    // beq x1,x2,8
    step(1'b1, 32'h00208463, 32'h104, 1'b1, 1'b0, acc);
    chk("beq_bt", 128'(out_branch_type), 128'(BEQ));
    chk("beq_rw", 128'(out_reg_write), 128'(NOREGWRITE));
    chk("beq_rr", 128'(out_reg_read), 128'(2'b11));
    chk("beq_imm", 128'(out_imm_type), 128'(BTYPE));
    // illegal words
    step(1'b1, 32'hFFFFFFFF, 32'h108, 1'b1, 1'b0, acc);
    chk("ill1_flag", 128'(out_illegal), 128'(1));
    chk("ill1_mw", 128'(out_mem_write), 128'(0));
    step(1'b1, 32'h0000307B, 32'h10C, 1'b1, 1'b0, acc);
    chk("ill2_flag", 128'(out_illegal), 128'(1));
    chk("ill2_mw", 128'(out_mem_write), 128'(0));
    chk("ill_cnt2", 128'(illegal_cnt), 128'(2));
    step(1'b1, 32'hFFFFFFFF, 32'h110, 1'b1, 1'b0, acc);
    step(1'b1, 32'hFFFFFFFF, 32'h114, 1'b1, 1'b0, acc);
    chk("sat_cnt_w2", 128'(cnt2), 128'(3));
    chk("cnt_4", 128'(illegal_cnt), 128'(4));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // stall stream: O and S fill, then drain in order
    strm = '{32'h00100113, 32'h00202183, 32'h40418233, 32'h0062A023};
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
      step(1'b1, strm[k], 32'h200 + 32'(k * 4), (cyc >= 5), 1'b0, acc);
      if (acc) begin
        k++;
        if (k == 2) chk("stall_in_ready", 128'(in_ready), 128'(0));
      end
    end
    chk("stream_all_accepted", 128'(k), 128'(4));
    for (int j = 0; j < 3; j++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // flush with both entries full and an illegal word offered
    step(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00208463, 32'h304, 1'b0, 1'b0, acc);
    cnt_before = cnt_exp;
    step(1'b1, 32'hFFFFFFFF, 32'h308, 1'b0, 1'b1, acc);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_cnt", 128'(illegal_cnt), 128'(cnt_before));

    // mul x1,x1,x2
    step(1'b1, 32'h022080B3, 32'h400, 1'b1, 1'b0, acc);
`ifdef RV32M_EN
    chk("mul_md", 128'(out_muldiv), 128'(1));
    chk("mul_op", 128'(out_muldiv_op), 128'(0));
    chk("mul_ill", 128'(out_illegal), 128'(0));
`else
    chk("mul_ill", 128'(out_illegal), 128'(1));
    chk("mul_md", 128'(out_muldiv), 128'(0));
`endif

    // reset while both entries are occupied
    step(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00208463, 32'h504, 1'b0, 1'b0, acc);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_cnt", 128'(illegal_cnt), 128'(0));
    q.delete(); cnt_exp = 0; cnt2_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // random traffic with back-pressure and occasional flush
    for (int n = 0; n < 3000; n++) begin
      ins_r = gen_instr();
      pc_r  = $urandom();
      step(($urandom_range(0, 3) != 0), ins_r, pc_r, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0), acc);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
